// File: rtl/updown_counter_pkg.sv
// Shared types and parameter checks for the updown_counter family.
package counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    function automatic bit params_legal(input int unsigned width,
                                        input int unsigned modulus,
                                        input int unsigned prescale);
        return (width >= 1) && (width <= 31) &&
               (modulus >= 2) &&
               (64'(modulus) <= (64'd1 << width)) &&
               (prescale >= 1);
    endfunction

endpackage

// File: rtl/updown_counter_if.sv
// Control/status bundle between a counter user (master) and updown_counter (slave).
interface updown_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             enable;
    logic             up_down;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             clear_flags;
    logic [WIDTH-1:0] counter_out;
    logic             tc;
    logic             overflow;
    logic             underflow;

    modport master (
        output enable, up_down, load, load_value, clear_flags,
        input  counter_out, tc, overflow, underflow
    );

    modport slave (
        input  enable, up_down, load, load_value, clear_flags,
        output counter_out, tc, overflow, underflow
    );
endinterface

// File: rtl/updown_counter_prescaler.sv
// count_prescaler: divides enabled cycles by PRESCALE into single-cycle step strobes.
module count_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic enable,
    output logic step
);
    localparam int unsigned     PW   = $clog2(PRESCALE) + 1;
    localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]   ONE  = PW'(1);

    logic [PW-1:0] presc_q;

    // With PRESCALE = 1, LAST is 0 so presc_q never leaves 0 and step == enable.
    assign step = enable && (presc_q == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            presc_q <= '0;
        end else if (enable) begin
            presc_q <= (presc_q == LAST) ? '0 : presc_q + ONE;
        end
    end

endmodule

// File: rtl/updown_counter.sv
// Parametrised up/down counter with load, prescaler, terminal-count pulse and sticky flags.
// Define UPDOWN_COUNTER_SAT_EN to saturate at the range ends instead of wrapping.
module updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 2**WIDTH,
    parameter int unsigned PRESCALE = 1
) (
    input logic              clk,
    input logic              reset,
    updown_counter_if.slave  bus
);
    if (!params_legal(WIDTH, MODULUS, PRESCALE)) begin : g_param_check
        $fatal(1, "updown_counter: illegal WIDTH/MODULUS/PRESCALE combination");
    end

    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   ONE_EXT = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
`ifdef UPDOWN_COUNTER_SAT_EN
    localparam logic [WIDTH-1:0] WRAP_UP = MAX_CNT;
    localparam logic [WIDTH-1:0] WRAP_DN = '0;
`else
    localparam logic [WIDTH-1:0] WRAP_UP = '0;
    localparam logic [WIDTH-1:0] WRAP_DN = MAX_CNT;
`endif

    logic [WIDTH-1:0] count_q;
    logic             tc_q, overflow_q, underflow_q;

    logic             step, count_up, boundary, set_ovf, set_unf;
    logic [WIDTH:0]   count_ext, inc_ext, dec_ext, load_ext;
    logic [WIDTH-1:0] step_next, load_clamped;

    count_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_presc (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.load),
        .enable(bus.enable),
        .step  (step)
    );

    // Boundaries are found in WIDTH+1 bits: inc reaching MODULUS, or dec borrowing below 0.
    always_comb begin
        count_ext    = {1'b0, count_q};
        inc_ext      = count_ext + ONE_EXT;
        dec_ext      = count_ext - ONE_EXT;
        load_ext     = {1'b0, bus.load_value};
        count_up     = (bus.up_down == DIR_UP);
        load_clamped = (load_ext < MOD_EXT) ? bus.load_value : MAX_CNT;
        step_next    = count_q;
        boundary     = 1'b0;
        if (count_up) begin
            boundary  = (inc_ext == MOD_EXT);
            step_next = boundary ? WRAP_UP : inc_ext[WIDTH-1:0];
        end else begin
            boundary  = dec_ext[WIDTH];
            step_next = boundary ? WRAP_DN : dec_ext[WIDTH-1:0];
        end
        set_ovf = step && !bus.load && boundary && count_up;
        set_unf = step && !bus.load && boundary && !count_up;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= '0;
            tc_q        <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            if (bus.load) begin
                count_q <= load_clamped;
            end else if (step) begin
                count_q <= step_next;
                tc_q    <= boundary;
            end
            overflow_q  <= (overflow_q  && !bus.clear_flags) || set_ovf;
            underflow_q <= (underflow_q && !bus.clear_flags) || set_unf;
        end
    end

    assign bus.counter_out = count_q;
    assign bus.tc          = tc_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;

endmodule

// File: tb/tb_updown_counter.sv
// Scoreboard bench for updown_counter: three configurations driven with directed vectors.
module tb_updown_counter;

`ifdef UPDOWN_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        int    dut;
        string name;
        int    cnt;
        int    tc;
        int    ov;
        int    un;
    } exp_t;

    logic clk;
    logic reset;
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pexp[9] = '{0, 0, 1, 1, 1, 2, 2, 2, 3};

    updown_counter_if #(.WIDTH(4)) if0 ();
    updown_counter_if #(.WIDTH(4)) if1 ();
    updown_counter_if #(.WIDTH(4)) if2 ();

    updown_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(1)) u_m16 (.clk(clk), .reset(reset), .bus(if0));
    updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_m10 (.clk(clk), .reset(reset), .bus(if1));
    updown_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(3)) u_p3  (.clk(clk), .reset(reset), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic zero_inputs();
        if0.enable = 1'b0; if0.up_down = 1'b0; if0.load = 1'b0; if0.load_value = '0; if0.clear_flags = 1'b0;
        if1.enable = 1'b0; if1.up_down = 1'b0; if1.load = 1'b0; if1.load_value = '0; if1.clear_flags = 1'b0;
        if2.enable = 1'b0; if2.up_down = 1'b0; if2.load = 1'b0; if2.load_value = '0; if2.clear_flags = 1'b0;
    endtask

    task automatic push(input int d, input string name, input int cnt, input int tc, input int ov, input int un);
        exp_t e;
        e.dut = d; e.name = name; e.cnt = cnt; e.tc = tc; e.ov = ov; e.un = un;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of stimulus on DUT d and queue the response expected after the next edge.
    task automatic v(input int d, input int rst, input int en, input int ud, input int ld, input int lv,
                     input int cf, input string name, input int cnt, input int tc, input int ov, input int un);
        @(negedge clk);
        reset = 1'(rst);
        zero_inputs();
        case (d)
            0: begin if0.enable = 1'(en); if0.up_down = 1'(ud); if0.load = 1'(ld); if0.load_value = 4'(lv); if0.clear_flags = 1'(cf); end
            1: begin if1.enable = 1'(en); if1.up_down = 1'(ud); if1.load = 1'(ld); if1.load_value = 4'(lv); if1.clear_flags = 1'(cf); end
            default: begin if2.enable = 1'(en); if2.up_down = 1'(ud); if2.load = 1'(ld); if2.load_value = 4'(lv); if2.clear_flags = 1'(cf); end
        endcase
        push(d, name, cnt, tc, ov, un);
    endtask

    always @(posedge clk) begin
        exp_t e;
        int a_cnt, a_tc, a_ov, a_un;
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.dut)
                0: begin a_cnt = int'(if0.counter_out); a_tc = int'(if0.tc); a_ov = int'(if0.overflow); a_un = int'(if0.underflow); end
                1: begin a_cnt = int'(if1.counter_out); a_tc = int'(if1.tc); a_ov = int'(if1.overflow); a_un = int'(if1.underflow); end
                default: begin a_cnt = int'(if2.counter_out); a_tc = int'(if2.tc); a_ov = int'(if2.overflow); a_un = int'(if2.underflow); end
            endcase
            checks++;
            if (a_cnt != e.cnt || a_tc != e.tc || a_ov != e.ov || a_un != e.un) begin
                errors++;
                $display("FAIL %s (dut%0d): got cnt=%0d tc=%0d ov=%0d un=%0d, expected cnt=%0d tc=%0d ov=%0d un=%0d",
                         e.name, e.dut, a_cnt, a_tc, a_ov, a_un, e.cnt, e.tc, e.ov, e.un);
            end
        end
    end

    initial begin
        reset = 1'b1;
        zero_inputs();

        // Reset held two cycles on all instances.
        for (int i = 0; i < 2; i++) begin
            v(0, 1, 0, 0, 0, 0, 0, "reset_m16", 0, 0, 0, 0);
            push(1, "reset_m10", 0, 0, 0, 0);
            push(2, "reset_p3", 0, 0, 0, 0);
        end

        // MODULUS=16: full up sweep, wrap, sticky overflow, clear vs set.
        for (int k = 1; k <= 15; k++) v(0, 0, 1, 1, 0, 0, 0, "m16_up", k, 0, 0, 0);
        v(0, 0, 1, 1, 0, 0, 0, "m16_up_wrap",      0, 1, 1, 0);
        v(0, 0, 0, 0, 0, 0, 0, "m16_ov_sticky",    0, 0, 1, 0);
        v(0, 0, 1, 1, 0, 0, 1, "m16_clear_ov",     1, 0, 0, 0);
        v(0, 0, 0, 0, 1, 15, 0, "m16_load15",     15, 0, 0, 0);
        v(0, 0, 1, 1, 0, 0, 1, "m16_clear_vs_set", SAT ? 15 : 0, 1, 1, 0);
        v(0, 0, 0, 0, 0, 0, 0, "m16_tc_one_cycle", SAT ? 15 : 0, 0, 1, 0);
        v(0, 0, 0, 0, 1, 5, 1, "m16_load_clear",   5, 0, 0, 0);
        v(0, 0, 0, 0, 1, 14, 0, "m16_load14",     14, 0, 0, 0);
        v(0, 0, 1, 1, 0, 0, 0, "m16_to15",        15, 0, 0, 0);
        v(0, 0, 1, 1, 0, 0, 0, "m16_top_step1",    SAT ? 15 : 0, 1, 1, 0);
        v(0, 0, 1, 1, 0, 0, 0, "m16_top_step2",    SAT ? 15 : 1, SAT ? 1 : 0, 1, 0);
        v(0, 0, 0, 0, 1, 0, 1, "m16_load0",        0, 0, 0, 0);
        v(0, 0, 1, 0, 0, 0, 0, "m16_bottom_step1", SAT ? 0 : 15, 1, 0, 1);
        v(0, 0, 1, 0, 0, 0, 0, "m16_bottom_step2", SAT ? 0 : 14, SAT ? 1 : 0, 0, 1);

        // MODULUS=10: down wrap, clamp, priorities.
        v(1, 0, 0, 0, 1, 0, 0,  "m10_load0",          0, 0, 0, 0);
        v(1, 0, 1, 0, 0, 0, 0,  "m10_down_wrap",      SAT ? 0 : 9, 1, 0, 1);
        v(1, 0, 0, 0, 0, 0, 1,  "m10_clear_un",       SAT ? 0 : 9, 0, 0, 0);
        v(1, 0, 0, 0, 1, 12, 0, "m10_clamp12",        9, 0, 0, 0);
        v(1, 0, 0, 0, 1, 10, 0, "m10_clamp10",        9, 0, 0, 0);
        v(1, 0, 1, 1, 1, 3, 0,  "m10_load_wins",      3, 0, 0, 0);
        v(1, 0, 1, 1, 0, 0, 0,  "m10_up",             4, 0, 0, 0);
        v(1, 0, 0, 0, 1, 9, 0,  "m10_load9",          9, 0, 0, 0);
        v(1, 0, 1, 1, 0, 0, 0,  "m10_up_wrap",        SAT ? 9 : 0, 1, 1, 0);
        v(1, 1, 0, 0, 1, 5, 0,  "m10_reset_over_load", 0, 0, 0, 0);

        // PRESCALE=3: step every third enabled cycle, hold, load and reset restart.
        for (int i = 0; i < 9; i++) v(2, 0, 1, 1, 0, 0, 0, "p3_run", pexp[i], 0, 0, 0);
        v(2, 0, 1, 1, 0, 0, 0, "p3_en1",           3, 0, 0, 0);
        v(2, 0, 0, 1, 0, 0, 0, "p3_hold_a",        3, 0, 0, 0);
        v(2, 0, 0, 1, 0, 0, 0, "p3_hold_b",        3, 0, 0, 0);
        v(2, 0, 1, 1, 0, 0, 0, "p3_en2",           3, 0, 0, 0);
        v(2, 0, 1, 1, 0, 0, 0, "p3_resume_step",   4, 0, 0, 0);
        v(2, 0, 1, 1, 0, 0, 0, "p3_mid",           4, 0, 0, 0);
        v(2, 0, 1, 1, 1, 8, 0, "p3_load_mid",      8, 0, 0, 0);
        v(2, 0, 1, 1, 0, 0, 0, "p3_after_load_a",  8, 0, 0, 0);
        v(2, 0, 1, 1, 0, 0, 0, "p3_after_load_b",  8, 0, 0, 0);
        v(2, 0, 1, 1, 0, 0, 0, "p3_restart_step",  9, 0, 0, 0);
        v(2, 0, 1, 1, 0, 0, 0, "p3_pre_reset",     9, 0, 0, 0);
        v(2, 1, 1, 1, 0, 0, 0, "p3_reset",         0, 0, 0, 0);
        v(2, 0, 1, 1, 0, 0, 0, "p3_post_reset_a",  0, 0, 0, 0);
        v(2, 0, 1, 1, 0, 0, 0, "p3_post_reset_b",  0, 0, 0, 0);
        v(2, 0, 1, 1, 0, 0, 0, "p3_post_reset_step", 1, 0, 0, 0);

        @(negedge clk);
        zero_inputs();
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
